// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_t;

  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps every register address to zero once per request,
// then raises a one-cycle done pulse.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_done,
  output logic              o_sweep_we,
  output logic [ADDR_W-1:0] o_sweep_addr
);

  clr_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_next = ST_CLEAR;
          w_ptr_next   = '0;
        end
      end
      ST_CLEAR: begin
        // Pointer parks on the last address rather than wrapping.
        if (r_ptr == {ADDR_W{1'b1}}) begin
          w_state_next = ST_DONE;
        end else begin
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_busy       = (r_state == ST_CLEAR);
  assign o_clr_done   = (r_state == ST_DONE);
  assign o_sweep_we   = o_busy;
  assign o_sweep_addr = r_ptr;

endmodule

// File: rtl/regfile_multiport.sv
// Register file: one write port, NUM_RD combinational read ports with write bypass,
// and a hardware clear sweep. Define REGFILE_ZERO_REG_EN to hardwire address 0 to zero.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_wr_en;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clr_req    (clr_req),
    .o_busy       (busy),
    .o_clr_done   (clr_done),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr)
  );

`ifdef REGFILE_ZERO_REG_EN
  assign w_wr_en = we && !busy && (wa != '0);
`else
  assign w_wr_en = we && !busy;
`endif

  // Sweep and user writes are exclusive: user writes are blocked while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[wa] <= wd;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = ra[k*ADDR_W +: ADDR_W];
    assign w_rd = (w_wr_en && (wa == w_ra)) ? wd : r_mem[w_ra];

`ifdef REGFILE_ZERO_REG_EN
    assign rd[k*DATA_W +: DATA_W] = (w_ra == '0) ? '0 : w_rd;
`else
    assign rd[k*DATA_W +: DATA_W] = w_rd;
`endif
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport with a read-data scoreboard.
module tb_regfile_multiport;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [DW-1:0] Zero55 = 8'h00;
`else
  localparam logic [DW-1:0] Zero55 = 8'h55;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           we;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic           clr_req;
  logic           busy;
  logic           clr_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string          tag;
    int unsigned    port;
    logic [DW-1:0]  exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rd       (rd),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned port, input logic [DW-1:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, 32'(rd[e.port*DW +: DW]), 32'(e.exp));
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ra(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    ra = {p1, p0};
  endtask

  initial begin
    int n;
    rst_n = 1'b0; we = 1'b0; clr_req = 1'b0; wa = '0; wd = '0; ra = '0;

    // Reset state
    step(); #1;
    set_ra(3'd3, 3'd7); #1;
    push("rst_rd0", 0, 8'h00);
    push("rst_rd1", 1, 8'h00);
    drain();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Write then read on both ports
    we = 1'b1; wa = 3'd3; wd = 8'hA5;
    step();
    wa = 3'd5; wd = 8'h3C;
    step();
    we = 1'b0;
    set_ra(3'd3, 3'd5); #1;
    push("wr_rd0", 0, 8'hA5);
    push("wr_rd1", 1, 8'h3C);
    drain();

    // Bypass: port 0 sees new data before the edge; port 1 is unaffected
    we = 1'b1; wa = 3'd6; wd = 8'h77;
    set_ra(3'd6, 3'd3); #1;
    push("byp_rd0", 0, 8'h77);
    push("byp_rd1", 1, 8'hA5);
    drain();
    step();
    we = 1'b0; #1;
    push("byp_stored", 0, 8'h77);
    drain();

    // Fill everything with FF, then sweep
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = AW'(i); wd = 8'hFF;
      step();
    end
    we = 1'b0;
    set_ra(3'd7, 3'd1); #1;
    push("fill_rd0", 0, 8'hFF);
    push("fill_rd1", 1, 8'hFF);
    drain();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // Writes during the sweep must be ignored and must not bypass
      we = 1'b1; wa = 3'd7; wd = 8'hAB;
      set_ra(3'd7, 3'd7); #1;
      chk($sformatf("clr_busy_%0d", i), 32'(busy), 32'd1);
      chk($sformatf("clr_nodone_%0d", i), 32'(clr_done), 32'd0);
      push($sformatf("clr_nobyp_%0d", i), 0, 8'hFF);
      drain();
      step();
    end
    we = 1'b0; #1;
    chk("clr_end_busy", 32'(busy), 32'd0);
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    step();
    chk("clr_done_low", 32'(clr_done), 32'd0);
    chk("clr_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      set_ra(AW'(i), AW'(7 - i)); #1;
      push($sformatf("clr_zero_a%0d", i), 0, 8'h00);
      push($sformatf("clr_zero_b%0d", i), 1, 8'h00);
      drain();
    end

    // Simultaneous clear request and write: write lands, sweep erases it
    step();
    we = 1'b1; wa = 3'd2; wd = 8'h12; clr_req = 1'b1;
    step();
    we = 1'b0; clr_req = 1'b0;
    set_ra(3'd2, 3'd0); #1;
    push("sim_committed", 0, 8'h12);
    drain();
    n = 0;
    while (!clr_done && n < 20) begin
      step();
      n++;
    end
    chk("sim_done_seen", 32'(clr_done), 32'd1);
    step(); #1;
    push("sim_erased", 0, 8'h00);
    drain();

    // Address 0 behaviour (hardwired zero only with the macro)
    we = 1'b1; wa = 3'd0; wd = 8'h55;
    set_ra(3'd0, 3'd0); #1;
    push("zr_bypass", 0, Zero55);
    drain();
    step();
    we = 1'b0; #1;
    push("zr_stored", 0, Zero55);
    push("zr_stored1", 1, Zero55);
    drain();

    // Reset in the middle of a sweep
    we = 1'b1; wa = 3'd1; wd = 8'h9A;
    step();
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    set_ra(3'd1, 3'd3); #1;
    push("mid_pre_rd0", 0, 8'h9A);
    drain();
    chk("mid_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    push("mid_rst_rd0", 0, 8'h00);
    push("mid_rst_rd1", 1, 8'h00);
    drain();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(clr_done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
